wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter for the RV32I core's single register-file write port. Two producers, the execute unit (requester 0) and the load unit (requester 1), present destination/data pairs over valid/ready handshakes. The block grants one per cycle round-robin and drives a registered write beat (`we`/`wa`/`wdata`) into the regfile. It also exposes that in-flight beat to the decode read ports for same-cycle bypass.

## Interface
- `XLEN`, 32: data width
- `CNT_W`, 16: width of the saturating contention counter
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; low clears all state
- `v0`, `v1`  in  1  requester valid
- `rdy0`, `rdy1`  out  1  grant/ready (combinational)
- `a0`, `a1`  in  5  destination register
- `d0`, `d1`  in  XLEN  write data
- `we`  out  1  regfile write enable (registered)
- `wa`  out  5  regfile write address (registered)
- `wdata`  out  XLEN  regfile write data (registered)
- `ra1`, `ra2`  in  5  decode read addresses
- `byp1_hit`, `byp2_hit`  out  1  in-flight write matches read address
- `byp1_data`, `byp2_data`  out  XLEN  bypass data
- `contend_cnt`  out  CNT_W  cycles with both requesters valid, saturating

## Operation
- Handshake: transfer on `vN && rdyN`. `rdyN` depends only on `v0`, `v1` and the priority pointer, never on `aN`/`dN`.
- At most one `rdy` is high per cycle.
- Only one requester valid: that requester is granted.
- Both valid: the requester named by priority pointer `prio` is granted; the other stalls. A requester must hold `vN`, `aN` and `dN` stable until its transfer completes.
- Priority update: after any grant to N, `prio` becomes the other requester. With no grant, `prio` holds. Reset value is 0.
- Output stage, loaded every cycle:
  - On transfer: `we` = (`aN != 0`), `wa` = `aN`, `wdata` = `dN`.
  - Writes to x0 are accepted (`rdy` high) but produce `we` = 0.
  - No transfer: `we` = 0; `wa`/`wdata` hold their previous value.
- Contention counter: increments on each cycle with `v0 && v1`. It saturates at all-ones and does not wrap.
- Bypass: see Configuration.

## Timing
- Handshake to `we` high: 1 cycle, i.e. the beat is visible on the cycle after the transfer edge. The regfile commits it on the following edge.
- Throughput is one write per cycle. Sustained dual-valid traffic gives strict alternation 0,1,0,1… starting from the current `prio`.
- Reset values: `we`=0, `wa`=0, `wdata`=0, `prio`=0, `contend_cnt`=0, `byp*_hit`=0, `byp*_data`=0.
- Reset asserted mid-operation: the output beat is dropped immediately (asynchronously), the pointer returns to 0, and the counter is cleared. Requesters must re-present after reset deassertion.
- While `reset` is low, `rdy0`/`rdy1` are forced low.

## Configuration
- `WB_BYPASS_EN` defined:
  - `bypK_hit` = `we && wa == raK && raK != 0`.
  - `bypK_data` = `wdata` when hit, else 0.
  - Purely combinational off the output register. Decode muxes it over regfile data, covering the regfile's read-before-write gap.
- Undefined: `bypK_hit` and `bypK_data` are tied to 0, and no comparators are synthesized. The pipeline must stall on the hazard instead.

## Structure
- Shared package `rv32i_pkg`:
  - `XLEN`
  - `REG_ADDR_W` = 5
  - `REG_ZERO` = 5'd0
  - requester index constants `WB_REQ_EXE` = 0, `WB_REQ_LSU` = 1
- One sub-module `rr_arb2`: 2-way round-robin grant plus pointer register with clock and async reset. It is reused for memory-port sharing.
- Bypass compare stays inline. It is duplicated for both read ports.

## Test plan
- Reset then idle: all outputs 0; `rdy0` = `rdy1` = 0 while `reset` low.
- Single producer: `v0`=1, `a0`=5, `d0`=0xDEADBEEF for one cycle → `rdy0`=1; next cycle `we`=1, `wa`=5, `wdata`=0xDEADBEEF; the cycle after, `we`=0.
- Contention: `v0`=`v1`=1 held for 4 cycles with distinct addresses 3/7 → grants 0,1,0,1; `we` beats alternate 3,7,3,7; `contend_cnt`=4.
- x0 drop: `v1`=1, `a1`=0, `d1`=0x1234 → `rdy1`=1, next cycle `we`=0.
- Bypass (`WB_BYPASS_EN`): write to x9 with 0xA5A5A5A5 in flight, `ra1`=9, `ra2`=10 → `byp1_hit`=1, `byp1_data`=0xA5A5A5A5, `byp2_hit`=0. Without the macro, both hits are 0.
- Reset mid-beat: assert `reset` low while `we`=1 → `we` drops without waiting for a clock edge. After release, with both valid, requester 0 is granted first.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I widths, register constants and writeback requester indices
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int WB_REQ_EXE = 0;
  localparam int WB_REQ_LSU = 1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant with a pointer that moves to the loser after each grant
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic prio;
  always_comb gnt = !reset ? 2'b00 : (req == 2'b11) ? (prio ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clk or negedge reset)
    if (!reset) prio <= 1'b0;
    else if (|gnt) prio <= gnt[0];
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter driving a registered regfile write beat.
// Define WB_BYPASS_EN to expose the in-flight beat to the decode read ports.
module wb_arbiter import rv32i_pkg::*; #(
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  v0,
  input  logic                  v1,
  output logic                  rdy0,
  output logic                  rdy1,
  input  logic [REG_ADDR_W-1:0] a0,
  input  logic [REG_ADDR_W-1:0] a1,
  input  logic [XLEN-1:0]       d0,
  input  logic [XLEN-1:0]       d1,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] wa,
  output logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  output logic                  byp1_hit,
  output logic                  byp2_hit,
  output logic [XLEN-1:0]       byp1_data,
  output logic [XLEN-1:0]       byp2_data,
  output logic [CNT_W-1:0]      contend_cnt
);
  logic [1:0] gnt;
  logic [REG_ADDR_W-1:0] sel_a;
  logic [XLEN-1:0] sel_d;
  rr_arb2 u_arb (.clk(clk), .reset(reset), .req({v1, v0}), .gnt(gnt));
  assign rdy0  = gnt[WB_REQ_EXE];
  assign rdy1  = gnt[WB_REQ_LSU];
  assign sel_a = gnt[WB_REQ_LSU] ? a1 : a0;
  assign sel_d = gnt[WB_REQ_LSU] ? d1 : d0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      we    <= 1'b0;
      wa    <= REG_ZERO;
      wdata <= '0;
    end else begin
      we <= (|gnt) && (sel_a != REG_ZERO);
      if (|gnt) begin
        wa    <= sel_a;
        wdata <= sel_d;
      end
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) contend_cnt <= '0;
    else if (v0 && v1 && !(&contend_cnt)) contend_cnt <= contend_cnt + 1'b1;
`ifdef WB_BYPASS_EN
  assign byp1_hit  = we && (wa == ra1) && (ra1 != REG_ZERO);
  assign byp2_hit  = we && (wa == ra2) && (ra2 != REG_ZERO);
  assign byp1_data = byp1_hit ? wdata : '0;
  assign byp2_data = byp2_hit ? wdata : '0;
`else
  logic unused_ra;
  assign unused_ra = ^{ra1, ra2};
  assign byp1_hit  = 1'b0;
  assign byp2_hit  = 1'b0;
  assign byp1_data = '0;
  assign byp2_data = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
  logic clk = 0, reset = 0, v0 = 0, v1 = 0;
  logic rdy0, rdy1, we, byp1_hit, byp2_hit;
  logic [4:0] a0 = 0, a1 = 0, ra1 = 0, ra2 = 0, wa;
  logic [31:0] d0 = 0, d1 = 0, wdata, byp1_data, byp2_data;
  logic [15:0] contend_cnt;
  int checks = 0, errors = 0;

  wb_arbiter dut (.clk(clk), .reset(reset), .v0(v0), .v1(v1), .rdy0(rdy0), .rdy1(rdy1),
    .a0(a0), .a1(a1), .d0(d0), .d1(d1), .we(we), .wa(wa), .wdata(wdata), .ra1(ra1), .ra2(ra2),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp1_data(byp1_data), .byp2_data(byp2_data),
    .contend_cnt(contend_cnt));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    v0 = 1; v1 = 1;
    repeat (2) step();
    checks++; if ({rdy0, rdy1} !== 2'b00) begin errors++; $display("FAIL reset_rdy got %b want 00", {rdy0, rdy1}); end
    checks++; if ({we, wa, wdata} !== 38'd0) begin errors++; $display("FAIL reset_beat got we=%b wa=%0d wdata=%h want 0", we, wa, wdata); end
    checks++; if (contend_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", contend_cnt); end
    checks++; if ({byp1_hit, byp2_hit, byp1_data, byp2_data} !== 66'd0) begin errors++; $display("FAIL reset_byp got %b%b %h %h want 0", byp1_hit, byp2_hit, byp1_data, byp2_data); end
    v0 = 0; v1 = 0;
    #2 reset = 1;
    step();
    checks++; if ({we, rdy0, rdy1, contend_cnt} !== 19'd0) begin errors++; $display("FAIL idle got we=%b rdy=%b%b cnt=%0d want 0", we, rdy0, rdy1, contend_cnt); end
  endtask

  task automatic test_single();
    v0 = 1; a0 = 5; d0 = 32'hDEADBEEF;
    #1;
    checks++; if ({rdy0, rdy1} !== 2'b10) begin errors++; $display("FAIL single_rdy got %b want 10", {rdy0, rdy1}); end
    step(); v0 = 0;
    checks++; if ({we, wa, wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL single_beat got we=%b wa=%0d wdata=%h want 1 5 deadbeef", we, wa, wdata); end
    step();
    checks++; if ({we, wa} !== {1'b0, 5'd5}) begin errors++; $display("FAIL single_idle got we=%b wa=%0d want 0 5", we, wa); end
  endtask

  task automatic test_x0_drop();
    v1 = 1; a1 = 0; d1 = 32'h1234;
    #1;
    checks++; if ({rdy0, rdy1} !== 2'b01) begin errors++; $display("FAIL x0_rdy got %b want 01", {rdy0, rdy1}); end
    step(); v1 = 0;
    checks++; if ({we, wa, wdata} !== {1'b0, 5'd0, 32'h1234}) begin errors++; $display("FAIL x0_beat got we=%b wa=%0d wdata=%h want 0 0 1234", we, wa, wdata); end
    step();
  endtask

  task automatic test_contention();
    logic [4:0] exp_a;
    v0 = 1; v1 = 1; a0 = 3; a1 = 7; d0 = 32'h33; d1 = 32'h77;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({rdy0, rdy1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_rdy%0d got %b", i, {rdy0, rdy1}); end
      checks++; if (contend_cnt !== 16'(i)) begin errors++; $display("FAIL cont_cnt%0d got %0d want %0d", i, contend_cnt, i); end
      step();
      exp_a = (i % 2 == 0) ? 5'd3 : 5'd7;
      checks++; if ({we, wa, wdata} !== {1'b1, exp_a, (i % 2 == 0) ? 32'h33 : 32'h77}) begin errors++; $display("FAIL cont_beat%0d got we=%b wa=%0d wdata=%h want wa=%0d", i, we, wa, wdata, exp_a); end
    end
    v0 = 0; v1 = 0;
    checks++; if (contend_cnt !== 16'd4) begin errors++; $display("FAIL cont_total got %0d want 4", contend_cnt); end
    step();
  endtask

  task automatic test_bypass();
    v1 = 1; a1 = 9; d1 = 32'hA5A5A5A5; ra1 = 9; ra2 = 10;
    step(); v1 = 0;
    checks++; if ({we, wa} !== {1'b1, 5'd9}) begin errors++; $display("FAIL byp_beat got we=%b wa=%0d want 1 9", we, wa); end
`ifdef WB_BYPASS_EN
    checks++; if ({byp1_hit, byp1_data} !== {1'b1, 32'hA5A5A5A5}) begin errors++; $display("FAIL byp1 got %b %h want 1 a5a5a5a5", byp1_hit, byp1_data); end
`else
    checks++; if ({byp1_hit, byp1_data} !== 33'd0) begin errors++; $display("FAIL byp1 got %b %h want 0 0", byp1_hit, byp1_data); end
`endif
    checks++; if ({byp2_hit, byp2_data} !== 33'd0) begin errors++; $display("FAIL byp2 got %b %h want 0 0", byp2_hit, byp2_data); end
    step();
    checks++; if ({byp1_hit, byp1_data} !== 33'd0) begin errors++; $display("FAIL byp1_idle got %b %h want 0 0", byp1_hit, byp1_data); end
    ra1 = 0; ra2 = 0;
  endtask

  task automatic test_reset_mid();
    v0 = 1; a0 = 4; d0 = 32'h44;
    step(); v0 = 0;
    checks++; if ({we, wa} !== {1'b1, 5'd4}) begin errors++; $display("FAIL mid_beat got we=%b wa=%0d want 1 4", we, wa); end
    #2 reset = 0; v0 = 1; v1 = 1; a1 = 6; d1 = 32'h66;
    #1;
    checks++; if ({we, wa, wdata, contend_cnt} !== 54'd0) begin errors++; $display("FAIL mid_async got we=%b wa=%0d wdata=%h cnt=%0d want 0", we, wa, wdata, contend_cnt); end
    checks++; if ({rdy0, rdy1} !== 2'b00) begin errors++; $display("FAIL mid_rdy got %b want 00", {rdy0, rdy1}); end
    #1 reset = 1;
    #1;
    checks++; if ({rdy0, rdy1} !== 2'b10) begin errors++; $display("FAIL post_rdy got %b want 10", {rdy0, rdy1}); end
    step();
    checks++; if ({we, wa, wdata} !== {1'b1, 5'd4, 32'h44}) begin errors++; $display("FAIL post_beat got we=%b wa=%0d wdata=%h want 1 4 44", we, wa, wdata); end
    checks++; if ({rdy0, rdy1} !== 2'b01) begin errors++; $display("FAIL post_rdy2 got %b want 01", {rdy0, rdy1}); end
    v0 = 0; v1 = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_x0_drop();
    test_contention();
    test_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
